// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = HDR_BYTES * BYTE_W;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  localparam int unsigned       DEF_MAX_WORDS = 1024;
  localparam logic [WORD_W-1:0] DEF_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, CKSUM, DONE, ERR
  } boot_state_e;

  // Instruction memory write payload.
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] instr;
  } imem_wr_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs stream bytes MSB-first into a 32-bit word; flags the byte that completes it.
module imem_word_packer
  import imem_boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full_c
);

  logic [BYTE_CNT_W-1:0] byte_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      word     <= {word[WORD_W-BYTE_W-1:0], byte_in};
      byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
    end
  end

  // High on the shift that delivers the last byte of a word.
  assign word_full_c = shift && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Loads instruction memory from a length-prefixed byte stream, then releases the core.
// Optional trailing XOR checksum byte when IMEM_BOOT_CKSUM_EN is defined.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int unsigned       MAX_WORDS = DEF_MAX_WORDS,
  parameter logic [WORD_W-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_data_i,
  output logic              byte_ready_o,
  output logic              wr_en_imem_o,
  output logic [WORD_W-1:0] wr_addr_imem_o,
  output logic [WORD_W-1:0] wr_instr_imem_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  words_loaded_o
);

`ifdef IMEM_BOOT_CKSUM_EN
  localparam boot_state_e LOAD_END = CKSUM;
`else
  localparam boot_state_e LOAD_END = DONE;
`endif

  boot_state_e       state, state_n;
  logic [CNT_W-1:0]  count, count_n, index_n, hdr_count;
  imem_wr_t          wr_q, wr_n;
  logic              wr_en_n, busy_n, done_n, err_n, cpu_reset_n;
  logic              byte_acc, start_go, pk_shift, pk_full_c;
  logic [WORD_W-1:0] pk_word, pk_word_next;

  always_comb begin
    byte_ready_o = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA: byte_ready_o = 1'b1;
`ifdef IMEM_BOOT_CKSUM_EN
      CKSUM:                byte_ready_o = 1'b1;
`endif
      default:              byte_ready_o = 1'b0;
    endcase
  end

  assign byte_acc     = byte_valid_i && byte_ready_o;
  assign start_go     = start_i && (state inside {IDLE, DONE, ERR});
  assign pk_shift     = byte_acc && (state == DATA);
  assign hdr_count    = {count[CNT_W-1:BYTE_W], byte_data_i};
  assign pk_word_next = (pk_word << BYTE_W) | WORD_W'(byte_data_i);

  imem_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (start_go),
    .shift       (pk_shift),
    .byte_in     (byte_data_i),
    .word        (pk_word),
    .word_full_c (pk_full_c)
  );

`ifdef IMEM_BOOT_CKSUM_EN
  logic [BYTE_W-1:0] cksum;

  // Running XOR over data bytes only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cksum <= '0;
    else if (start_go) cksum <= '0;
    else if (pk_shift) cksum <= cksum ^ byte_data_i;
  end
`endif

  // Next state and next values of every registered output.
  always_comb begin
    state_n = state;
    count_n = count;
    index_n = words_loaded_o;
    wr_n    = wr_q;
    wr_en_n = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start_go) begin
          state_n = LEN_HI;
          count_n = '0;
          index_n = '0;
        end
      end
      LEN_HI: begin
        if (byte_acc) begin
          count_n = {byte_data_i, BYTE_W'(0)};
          state_n = LEN_LO;
        end
      end
      LEN_LO: begin
        if (byte_acc) begin
          count_n = hdr_count;
          if (hdr_count == '0)                 state_n = LOAD_END;
          else if (32'(hdr_count) > MAX_WORDS) state_n = ERR;
          else                                 state_n = DATA;
        end
      end
      DATA: begin
        if (pk_full_c) begin
          state_n    = WRITE;
          wr_en_n    = 1'b1;
          wr_n.addr  = BASE_ADDR + (WORD_W'(words_loaded_o) << 2);
          wr_n.instr = pk_word_next;
        end
      end
      WRITE: begin
        index_n = words_loaded_o + CNT_W'(1);
        state_n = (index_n == count) ? LOAD_END : DATA;
      end
`ifdef IMEM_BOOT_CKSUM_EN
      CKSUM: begin
        if (byte_acc) state_n = (byte_data_i == cksum) ? DONE : ERR;
      end
`endif
      default: state_n = IDLE;
    endcase
    busy_n      = state_n inside {LEN_HI, LEN_LO, DATA, WRITE, CKSUM};
    done_n      = (state_n == DONE);
    err_n       = (state_n == ERR);
    // Core leaves reset only after a full cycle spent in DONE.
    cpu_reset_n = !((state == DONE) && (state_n == DONE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      words_loaded_o <= '0;
      wr_q           <= '0;
      wr_en_imem_o   <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      cpu_reset_o    <= 1'b1;
    end else begin
      state          <= state_n;
      count          <= count_n;
      words_loaded_o <= index_n;
      wr_q           <= wr_n;
      wr_en_imem_o   <= wr_en_n;
      busy_o         <= busy_n;
      done_o         <= done_n;
      err_o          <= err_n;
      cpu_reset_o    <= cpu_reset_n;
    end
  end

  assign wr_addr_imem_o  = wr_q.addr;
  assign wr_instr_imem_o = wr_q.instr;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes queued, monitor checks each strobe.
module tb_imem_boot_loader;

`ifdef IMEM_BOOT_CKSUM_EN
  localparam bit CKSUM_ON = 1'b1;
`else
  localparam bit CKSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        wr_en_imem_o;
  logic [31:0] wr_addr_imem_o;
  logic [31:0] wr_instr_imem_o;
  logic        cpu_reset_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] words_loaded_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;
  wr_exp_t exp_q[$];

  logic [7:0] s_main [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                              8'hAC, 8'h01, 8'h00, 8'h04};
  logic [7:0] s_one  [6]  = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .byte_valid_i    (byte_valid_i),
    .byte_data_i     (byte_data_i),
    .byte_ready_o    (byte_ready_o),
    .wr_en_imem_o    (wr_en_imem_o),
    .wr_addr_imem_o  (wr_addr_imem_o),
    .wr_instr_imem_o (wr_instr_imem_o),
    .cpu_reset_o     (cpu_reset_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .words_loaded_o  (words_loaded_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  wr_exp_t mon_e;
  always @(negedge clk) begin
    if (wr_en_imem_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h with nothing expected",
                 wr_addr_imem_o, wr_instr_imem_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", wr_addr_imem_o, mon_e.addr);
        chk("wr_instr", wr_instr_imem_o, mon_e.data);
        chk("ready_in_write", 32'(byte_ready_o), 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    int n;
    if (gap) begin
      byte_valid_i = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = (byte_ready_o === 1'b1);
      n++;
      @(posedge clk); #1;
    end
    byte_valid_i = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte 0x%02h not taken within %0d cycles", b, n);
    end
  endtask

  task automatic send_cks(input logic [7:0] c);
    if (CKSUM_ON) send_byte(c, 1'b0);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Poll done_o (want_done=1) or err_o (want_done=0) with a cycle budget.
  task automatic wait_flag(input bit want_done, input string name);
    bit hit;
    int n;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < 200) begin
      @(negedge clk);
      hit = want_done ? (done_o === 1'b1) : (err_o === 1'b1);
      n++;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: flag not seen after %0d cycles, got 0 expected 1", name, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_wr_en", 32'(wr_en_imem_o), 32'd0);
    chk("rst_ready", 32'(byte_ready_o), 32'd0);
    chk("rst_words", 32'(words_loaded_o), 32'd0);
    chk("rst_wr_addr", wr_addr_imem_o, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Two-word image, continuous valid.
    exp_q.push_back('{32'h0000_0000, 32'h2008_0005});
    exp_q.push_back('{32'h0000_0004, 32'hAC01_0004});
    pulse_start();
    chk("start_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 10; i++) send_byte(s_main[i], 1'b0);
    send_cks(8'h84);
    wait_flag(1'b1, "main_done");
    chk("main_cpu_reset_hold", 32'(cpu_reset_o), 32'd1);
    chk("main_words", 32'(words_loaded_o), 32'd2);
    @(negedge clk);
    chk("main_cpu_release", 32'(cpu_reset_o), 32'd0);
    chk("main_done_sticky", 32'(done_o), 32'd1);
    chk("main_addr_hold", wr_addr_imem_o, 32'h0000_0004);
    chk("main_instr_hold", wr_instr_imem_o, 32'hAC01_0004);
    chk("main_all_writes", 32'(exp_q.size()), 32'd0);

    // Restart from DONE, same image with gaps in valid.
    exp_q.push_back('{32'h0000_0000, 32'h2008_0005});
    exp_q.push_back('{32'h0000_0004, 32'hAC01_0004});
    pulse_start();
    chk("restart_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("restart_done_clr", 32'(done_o), 32'd0);
    chk("restart_words_clr", 32'(words_loaded_o), 32'd0);
    for (int i = 0; i < 10; i++) send_byte(s_main[i], 1'b1);
    send_cks(8'h84);
    wait_flag(1'b1, "gap_done");
    chk("gap_words", 32'(words_loaded_o), 32'd2);
    chk("gap_all_writes", 32'(exp_q.size()), 32'd0);

    // Oversized header 0x0401 aborts without writing.
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    wait_flag(1'b0, "big_err");
    chk("big_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("big_done", 32'(done_o), 32'd0);
    chk("big_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("big_err_sticky", 32'(err_o), 32'd1);
    chk("big_cpu_reset_stays", 32'(cpu_reset_o), 32'd1);
    pulse_start();
    chk("rearm_err_clr", 32'(err_o), 32'd0);
    chk("rearm_busy", 32'(busy_o), 32'd1);

    // One word with a start pulse mid-DATA that must be ignored.
    exp_q.push_back('{32'h0000_0000, 32'hAABB_CCDD});
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    pulse_start();
    chk("busy_start_ignored", 32'(busy_o), 32'd1);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_cks(8'h00);
    wait_flag(1'b1, "busy_start_done");
    chk("busy_start_words", 32'(words_loaded_o), 32'd1);
    chk("busy_start_writes", 32'(exp_q.size()), 32'd0);

    // Zero-length image: DONE with no writes, then start re-asserts core reset.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_cks(8'h00);
    wait_flag(1'b1, "zero_done");
    chk("zero_words", 32'(words_loaded_o), 32'd0);
    @(negedge clk);
    chk("zero_cpu_release", 32'(cpu_reset_o), 32'd0);
    pulse_start();
    chk("zero_restart_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("zero_restart_done", 32'(done_o), 32'd0);

    // Reset after two data bytes, then a clean single-word load.
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_ready", 32'(byte_ready_o), 32'd0);
    chk("midrst_wr_en", 32'(wr_en_imem_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back('{32'h0000_0000, 32'h1122_3344});
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_cks(8'h44);
    wait_flag(1'b1, "midrst_reload_done");
    chk("midrst_words", 32'(words_loaded_o), 32'd1);
    chk("midrst_writes", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_BOOT_CKSUM_EN
    exp_q.push_back('{32'h0000_0000, 32'h2008_0005});
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(s_one[i], 1'b0);
    send_byte(8'h2D, 1'b0);
    wait_flag(1'b1, "cksum_good");
    exp_q.push_back('{32'h0000_0000, 32'h2008_0005});
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(s_one[i], 1'b0);
    send_byte(8'h2C, 1'b0);
    wait_flag(1'b0, "cksum_bad");
    chk("cksum_bad_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("cksum_writes", 32'(exp_q.size()), 32'd0);
`else
    chk("one_word_len", 32'({s_one[0], s_one[1]}), 32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
